// File: rtl/uart_byte_fifo_bridge_pkg.sv
// Shared types for the UART byte FIFO bridge: byte width and the ingress/egress FSM encodings.
package uart_byte_fifo_bridge_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ING_IDLE     = 2'd0,
    ING_ACK      = 2'd1,
    ING_WAIT_LOW = 2'd2
  } ing_state_t;

  typedef enum logic [1:0] {
    EG_IDLE      = 2'd0,
    EG_WAIT_BUSY = 2'd1,
    EG_WAIT_DONE = 2'd2
  } eg_state_t;

endpackage

// File: rtl/uart_byte_fifo_bridge_if.sv
// Bundle of receiver-side, transmitter-side and status signals around the byte FIFO bridge.
interface uart_byte_fifo_bridge_if #(
  parameter int ADDR_W = 4
);
  import uart_byte_fifo_bridge_pkg::*;

  // Handshakes: rx_ready is a level held by the receiver until the bridge answers with a
  // one-cycle rx_clear; the bridge then waits for rx_ready to fall before taking another byte.
  // tx_send is a one-cycle pulse issued only while tx_busy is low; tx_data stays stable after it,
  // and the next send waits for tx_busy to rise and fall again.
  logic [BYTE_W-1:0] rx_data;
  logic              rx_ready;
  logic              rx_clear;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_send;
  logic              tx_busy;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;
  ing_state_t        ing_state;
  eg_state_t         eg_state;

  modport master (
    input  rx_data, rx_ready, tx_busy,
    output rx_clear, tx_data, tx_send, count, full, empty, overflow, ing_state, eg_state
  );

  modport slave (
    output rx_data, rx_ready, tx_busy,
    input  rx_clear, tx_data, tx_send, count, full, empty, overflow, ing_state, eg_state
  );

endinterface

// File: rtl/uart_byte_fifo_bridge_byte_fifo_mem.sv
// Circular byte store with registered occupancy, full and empty flags.
module byte_fifo_mem
  import uart_byte_fifo_bridge_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_nxt;

  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Storage is not reset; stale entries are unreachable once the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_byte_fifo_bridge.sv
// Elastic byte buffer from uart_receiver to uart_transmitter: acknowledges each received byte,
// queues it, and replays it with a single send pulse whenever the transmitter is idle.
module uart_byte_fifo_bridge
  import uart_byte_fifo_bridge_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic                     clk,
  input logic                     reset,
  uart_byte_fifo_bridge_if.master bus
);

  ing_state_t        ing_state;
  eg_state_t         eg_state;
  logic              rx_clear;
  logic              tx_send;
  logic [BYTE_W-1:0] tx_data;
  logic              overflow;
  logic              push;
  logic              pop;
  logic [BYTE_W-1:0] rd_data;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;

  // full/empty are registered, so a byte arriving on the same edge as a pop from a full FIFO is dropped.
  assign push = (ing_state == ING_IDLE) && bus.rx_ready && !full;
  assign pop  = (eg_state == EG_IDLE) && !empty && !bus.tx_busy;

  byte_fifo_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (bus.rx_data),
    .pop     (pop),
    .rd_data (rd_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ing_state <= ING_IDLE;
      rx_clear  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      rx_clear <= 1'b0;
      case (ing_state)
        ING_IDLE: begin
          if (bus.rx_ready) begin
            if (full) overflow <= 1'b1;
            rx_clear  <= 1'b1;
            ing_state <= ING_ACK;
          end
        end
        ING_ACK:      ing_state <= ING_WAIT_LOW;
        // A ready level that outlives the ack is the same byte, never a new one.
        ING_WAIT_LOW: if (!bus.rx_ready) ing_state <= ING_IDLE;
        default:      ing_state <= ING_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      eg_state <= EG_IDLE;
      tx_send  <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_send <= 1'b0;
      case (eg_state)
        EG_IDLE: begin
          if (pop) begin
            tx_data  <= rd_data;
            tx_send  <= 1'b1;
            eg_state <= EG_WAIT_BUSY;
          end
        end
        EG_WAIT_BUSY: if (bus.tx_busy)  eg_state <= EG_WAIT_DONE;
        EG_WAIT_DONE: if (!bus.tx_busy) eg_state <= EG_IDLE;
        default:      eg_state <= EG_IDLE;
      endcase
    end
  end

  assign bus.rx_clear  = rx_clear;
  assign bus.tx_send   = tx_send;
  assign bus.tx_data   = tx_data;
  assign bus.count     = count;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow;
  assign bus.ing_state = ing_state;
  assign bus.eg_state  = eg_state;

endmodule

// File: tb/tb_uart_byte_fifo_bridge.sv
// Bench for uart_byte_fifo_bridge: receiver driver, busy/done transmitter model and an in-order scoreboard.
module tb_uart_byte_fifo_bridge;
  import uart_byte_fifo_bridge_pkg::*;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_byte_fifo_bridge_if #(.ADDR_W(ADDR_W)) bus();

  uart_byte_fifo_bridge #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int cyc = 0;
  int send_cnt = 0;
  int clr_cnt = 0;
  int last_send_cyc = 0;
  int busy_cnt = 0;
  int busy_len = 3;
  bit hold_busy = 1'b0;

  typedef struct {
    logic [7:0] data;
    int         hold;
    int         busy_len;
    bit         block;
    logic [4:0] exp_count;
    bit         chk_lat;
  } vec_t;

  vec_t vecs[3];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Transmitter model: busy for busy_len cycles after every send, or stuck while hold_busy.
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy_cnt > 0) busy_cnt--;
      if (bus.rx_clear) clr_cnt++;
      if (bus.tx_send) begin
        check("send_while_busy", 32'(bus.tx_busy), 32'd0);
        send_cnt++;
        last_send_cyc = cyc;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_send: got %0h want none", bus.tx_data);
        end else begin
          check("tx_data", 32'(bus.tx_data), 32'(exp_q.pop_front()));
        end
        busy_cnt = busy_len;
      end
    end
    bus.tx_busy = hold_busy || (busy_cnt > 0);
  end

  task automatic send_byte(input logic [7:0] d, input int hold, input bit store, output int start);
    @(negedge clk);
    bus.rx_data  = d;
    bus.rx_ready = 1'b1;
    start = cyc + 1;
    if (store) exp_q.push_back(d);
    repeat (hold) @(negedge clk);
    bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (n < 2000 && !(exp_q.size() == 0 && bus.empty && !bus.tx_busy && bus.eg_state == EG_IDLE)) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 2000) begin
      bad++;
      $display("FAIL %s_drain: got %0d pending want 0", name, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, c0, s0;
    vecs[0] = '{8'hA5, 5, 3, 1'b0, 5'd0, 1'b1};
    vecs[1] = '{8'h5A, 20, 2, 1'b1, 5'd1, 1'b0};
    vecs[2] = '{8'hFF, 1, 1, 1'b0, 5'd0, 1'b0};

    reset = 1'b1;
    bus.rx_data  = 8'h00;
    bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_tx_send", 32'(bus.tx_send), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_rx_clear", 32'(bus.rx_clear), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single bytes, held ready levels and latency
    for (int i = 0; i < 3; i++) begin
      hold_busy = vecs[i].block;
      busy_len  = vecs[i].busy_len;
      repeat (2) @(negedge clk);
      c0 = clr_cnt;
      s0 = send_cnt;
      send_byte(vecs[i].data, vecs[i].hold, 1'b1, st);
      check("vec_clears", clr_cnt - c0, 32'd1);
      check("vec_count", 32'(bus.count), 32'(vecs[i].exp_count));
      if (vecs[i].chk_lat) check("vec_latency", last_send_cyc - st, 32'd1);
      hold_busy = 1'b0;
      drain("vec");
      check("vec_sends", send_cnt - s0, 32'd1);
      check("vec_count_end", 32'(bus.count), 32'd0);
    end

    // Burst while transmitter busy
    hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    s0 = send_cnt;
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 2, 1'b1, st);
    check("burst_count", 32'(bus.count), 32'd5);
    check("burst_no_send", send_cnt - s0, 32'd0);
    hold_busy = 1'b0;
    busy_len  = 2;
    drain("burst");
    check("burst_sends", send_cnt - s0, 32'd5);
    check("burst_count_end", 32'(bus.count), 32'd0);

    // Overflow: 17 bytes into 16 entries, last one dropped
    hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    c0 = clr_cnt;
    s0 = send_cnt;
    for (int i = 1; i <= 17; i++) send_byte(8'(8'h10 + i), 2, (i <= 16), st);
    check("ovf_full", 32'(bus.full), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd16);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_clears", clr_cnt - c0, 32'd17);
    hold_busy = 1'b0;
    drain("ovf");
    check("ovf_sends", send_cnt - s0, 32'd16);
    check("ovf_sticky", 32'(bus.overflow), 32'd1);
    check("ovf_empty", 32'(bus.empty), 32'd1);

    // Wrap-around stream
    busy_len = 3;
    s0 = send_cnt;
    for (int i = 0; i < 40; i++) send_byte(8'(i * 7 + 3), 2, 1'b1, st);
    drain("wrap");
    check("wrap_sends", send_cnt - s0, 32'd40);
    check("wrap_count", 32'(bus.count), 32'd0);

    // Reset mid-burst discards queued bytes
    hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) send_byte(8'(8'hC0 + i), 2, 1'b1, st);
    check("mid_count", 32'(bus.count), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_empty", 32'(bus.empty), 32'd1);
    check("mid_rst_full", 32'(bus.full), 32'd0);
    check("mid_rst_overflow", 32'(bus.overflow), 32'd0);
    check("mid_rst_tx_send", 32'(bus.tx_send), 32'd0);
    check("mid_rst_tx_data", 32'(bus.tx_data), 32'd0);
    hold_busy = 1'b0;
    repeat (2) @(negedge clk);
    s0 = send_cnt;
    send_byte(8'h3C, 2, 1'b1, st);
    drain("post_rst");
    check("post_rst_sends", send_cnt - s0, 32'd1);
    check("post_rst_tx_data", 32'(bus.tx_data), 32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_byte_fifo_bridge.md
Name: uart_byte_fifo_bridge

Overview:
- Elastic byte buffer between uart_receiver (upstream) and uart_transmitter (downstream) in the PC-to-PC loopback path.
- Accepts each byte flagged by the receiver's ready level and acknowledges it via the receiver's clear-ready input.
- Queues bytes in a circular FIFO and replays them to the transmitter with a single-cycle send pulse, one at a time, gated by transmitter busy.
- Keeps back-to-back PC bursts from being lost while the transmitter is still shifting out the previous byte.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock (same clock as UART blocks).
- reset  in  1  synchronous, active-high; debounced reset from top level.
- rx_data  in  8  byte from uart_receiver o_8_data.
- rx_ready  in  1  level from uart_receiver o_ready; stays high until cleared.
- rx_clear  out  1  one-cycle pulse to uart_receiver i_clear_ready.
- tx_data  out  8  byte to uart_transmitter data; registered, held stable between sends.
- tx_send  out  1  one-cycle pulse to uart_transmitter send.
- tx_busy  in  1  uart_transmitter busy.
- count  out  ADDR_W+1  current occupancy, range 0..DEPTH.
- full  out  1  high when count==DEPTH.
- empty  out  1  high when count==0.
- overflow  out  1  sticky; set when a byte is dropped because the FIFO is full.

Behaviour:
- Reset is synchronous and takes priority over all other logic. Reset values:
  - pointers 0, count 0, empty 1, full 0, overflow 0
  - rx_clear 0, tx_send 0, tx_data 8'h00
  - both FSMs in their IDLE state
- Storage:
  - DEPTH x 8 register array.
  - Write and read pointers are ADDR_W bits and wrap from DEPTH-1 to 0 naturally.
  - count tracks occupancy. Write-only: +1. Pop-only: -1. Write and pop in the same cycle: count unchanged, both pointers advance.
- Ingress FSM (ING_IDLE, ING_ACK, ING_WAIT_LOW):
  - ING_IDLE, rx_ready sampled high at edge k:
    - if not full: rx_data written at edge k, write pointer advances.
    - if full: byte dropped, overflow set to 1.
    - Either way, go to ING_ACK.
  - ING_ACK: rx_clear=1 for exactly one cycle (cycle after k), then go to ING_WAIT_LOW.
  - ING_WAIT_LOW: wait for rx_ready==0, then return to ING_IDLE. A single ready level is never written twice.
  - If rx_ready is still high 2 cycles after the ack, it is treated as the same byte (the FSM waits). There is no retry pulse.
- Egress FSM (EG_IDLE, EG_WAIT_BUSY, EG_WAIT_DONE):
  - EG_IDLE, not empty and tx_busy==0 at edge m:
    - tx_data <= mem[rd_ptr], read pointer advances (pop).
    - tx_send=1 during cycle m+1 only.
    - Go to EG_WAIT_BUSY.
  - EG_WAIT_BUSY: wait for tx_busy==1, then go to EG_WAIT_DONE.
  - EG_WAIT_DONE: wait for tx_busy==0, then return to EG_IDLE.
  - Only one byte is in flight at any time; a new tx_send is never issued while busy.
- Latency:
  - Empty FIFO, idle transmitter: rx_ready high at edge k gives tx_send high during cycle k+2. Write at k, empty drops at k, pop at k+1.
- Boundary cases:
  - Full and pop in the same cycle as an incoming byte: the full check uses the pre-edge count, so the byte is dropped. Documented behaviour, not a bug.
  - Write while empty: the written byte is not readable until the next edge. There is no bypass.
  - Reset mid-operation: queued bytes are discarded. An in-flight transmitter frame is not aborted by this block.
  - overflow clears only on reset.
- All outputs are registered; no combinational path from any input to any output.

Decomposition:
- Shared package/header holds:
  - ingress state encodings (ING_*) and egress state encodings (EG_*)
  - BYTE_W=8
- One natural sub-module: byte_fifo_mem. It contains the register array, pointers, count, full and empty, with push/pop inputs.
- The two FSMs stay in the top module.

Test Plan:
- Single byte: rx_data=8'hA5 with rx_ready pulse held 5 cycles, tx_busy idle -> one rx_clear pulse; tx_send one cycle at k+2 with tx_data=8'hA5; count returns to 0.
- Burst during busy: hold tx_busy=1, deliver 8'h01..8'h05 -> count=5, tx_send stays 0. Release busy with a busy/done model -> bytes sent in order 01..05, exactly 5 tx_send pulses.
- Overflow: busy stuck high, deliver 17 bytes (DEPTH=16) -> full=1, count=16, overflow=1, 17 rx_clear pulses, byte 17 absent from the output sequence.
- Wrap-around: 40 bytes streamed with transmitter busy lasting 3 cycles per byte -> output equals input order; pointers wrap twice; no loss.
- Held ready: rx_ready held high 20 cycles for one byte -> exactly one write, one rx_clear, count=1.
- Reset mid-burst: 3 bytes queued, assert reset one cycle -> count=0, empty=1, overflow=0, tx_send=0, tx_data=8'h00. A subsequent byte 8'h3C is transmitted normally.
